draw_player: RTL and testbench
==============================

// Module: draw_player
// PURPOSE
//  Pixel-pipeline stage after draw_bg; consumes its VGA timing bundle and RGB stream.
//  Overlays a square PLAYER_SIZE x PLAYER_SIZE sprite at a register-held position.
//  Position moves once per frame from four direction buttons, clamped to the screen.
//  Timing signals pass through with matching latency to the downstream stage / VGA out.
// PARAMETERS
//  INIT_X       512          reset x of sprite top-left corner (pixels)
//  INIT_Y       384          reset y of sprite top-left corner (pixels)
//  STEP         2            pixels moved per frame per held direction, 1..PLAYER_SIZE
//  PLAYER_COLOR vga_pkg::YELLOW  12-bit sprite fill colour
// PORTS
//  clk          in   1   65 MHz pixel clock
//  rst          in   1   synchronous, active-high reset
//  hcount_in    in   11  horizontal counter, 0..HBLANK_STOP-1
//  vcount_in    in   11  vertical counter, 0..VBLANK_STOP-1
//  hsync_in / vsync_in / hblank_in / vblank_in  in 1 each  upstream timing
//  rgb_in       in   12  upstream pixel colour
//  btn_left / btn_right / btn_up / btn_down     in 1 each  already-synchronised, level
//  hcount_out / vcount_out  out 11  hcount_in / vcount_in delayed 2 cycles
//  hsync_out / vsync_out / hblank_out / vblank_out  out 1 each  inputs delayed 2 cycles
//  rgb_out      out  12  composited pixel, 2 cycles after inputs
//  xpos / ypos  out  11  current sprite top-left position
// BEHAVIOUR
//  - Reset: all *_out and rgb_out = 0; xpos = INIT_X, ypos = INIT_Y; vblank history = 0.
//    Reset mid-frame takes effect next edge; stream resumes 2 cycles after rst falls.
//  - Frame tick: single-cycle pulse when vblank_in is 1 and its registered copy is 0.
//  - On tick only: dx = STEP*(btn_right - btn_left), dy = STEP*(btn_down - btn_up);
//    opposing buttons cancel (no motion on that axis). Position never changes mid-frame.
//  - Clamp: x in [0, SCREEN_WIDTH-PLAYER_SIZE], y in [0, SCREEN_HEIGHT-PLAYER_SIZE];
//    compute in signed 12 bit, saturate at bounds, no wrap-around.
//  - Stage 1: register timing + rgb_in; hit = ~hblank & ~vblank &
//    hcount in [xpos, xpos+PLAYER_SIZE) & vcount in [ypos, ypos+PLAYER_SIZE).
//  - Stage 2: rgb_out = hit ? PLAYER_COLOR : rgb_stage1; timing copied. Latency exactly 2.
//  - Blanking: rgb_out forced to BLACK whenever hblank_out|vblank_out is 1.
//  - Tick coinciding with a hit uses old position for that pixel (compare uses registered xpos/ypos).
// CONFIGURATION
//  PLAYER_BORDER_EN defined: pixels on the sprite's outermost row/column drawn BLACK,
//    interior PLAYER_COLOR (same latency, same hit region).
//  PLAYER_BORDER_EN undefined: whole sprite PLAYER_COLOR.
// STRUCTURE
//  vga_pkg: SCREEN_WIDTH, SCREEN_HEIGHT, PLAYER_SIZE, BLACK, YELLOW; add PLAYER_STEP,
//    PLAYER_INIT_X/Y constants used as parameter defaults.
//  Sub-module player_move_ctl: tick detection, button decode, clamped xpos/ypos registers.
//  draw_player top: 2-stage timing/rgb pipeline, hit compare, colour mux.
// TESTING
//  1 Reset, no buttons, full frame rgb_in=BLUE -> pixels x 512..526, y 384..398 YELLOW,
//    rest BLUE; timing out equals in delayed 2 cycles.
//  2 Hold btn_right 3 frames -> xpos 512,514,516,518 changing only 1 cycle after vblank rise.
//  3 Hold btn_left from xpos=1 -> xpos 0 and stays 0; hold btn_down until ypos=753, stays 753.
//  4 btn_left & btn_right & btn_up held one frame -> xpos unchanged, ypos -= 2.
//  5 Assert rst at hcount=600 mid-frame after moves -> next cycle outputs 0, xpos=512, ypos=384.
//  6 With PLAYER_BORDER_EN: pixel (512,384) and (526,390) BLACK, (513,385) YELLOW.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 1024x768@60 timing constants, colours and player sprite defaults
package vga_pkg;

   localparam int SCREEN_WIDTH  = 1024;
   localparam int SCREEN_HEIGHT = 768;
   localparam int HBLANK_STOP   = 1344;
   localparam int VBLANK_STOP   = 806;

   localparam int PLAYER_SIZE   = 15;
   localparam int PLAYER_STEP   = 2;
   localparam int PLAYER_INIT_X = 512;
   localparam int PLAYER_INIT_Y = 384;

   localparam logic [11:0] BLACK  = 12'h000;
   localparam logic [11:0] YELLOW = 12'hff0;
   localparam logic [11:0] BLUE   = 12'h00f;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblank;
      logic        vblank;
   } vga_timing_t;

   // Saturate a signed candidate coordinate into [0, hi].
   function automatic logic [10:0] clamp_pos(input logic signed [11:0] p,
                                             input logic signed [11:0] hi);
      if (p < 12'sd0)
         return '0;
      else if (p > hi)
         return hi[10:0];
      else
         return p[10:0];
   endfunction

endpackage

// File: rtl/player_move_ctl.sv
// rtl/player_move_ctl.sv - once-per-frame sprite position update from direction buttons
module player_move_ctl
   import vga_pkg::*;
#(
   parameter int INIT_X = PLAYER_INIT_X,
   parameter int INIT_Y = PLAYER_INIT_Y,
   parameter int STEP   = PLAYER_STEP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblank_in,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_up,
   input  logic        btn_down,
   output logic [10:0] xpos,
   output logic [10:0] ypos
);

   localparam logic signed [11:0] X_MAX = 12'(SCREEN_WIDTH - PLAYER_SIZE);
   localparam logic signed [11:0] Y_MAX = 12'(SCREEN_HEIGHT - PLAYER_SIZE);

   logic              vblank_q, vblank_d;
   logic [10:0]       xpos_q, xpos_d;
   logic [10:0]       ypos_q, ypos_d;
   logic              tick;
   logic signed [11:0] dx, dy;

   always_comb begin
      vblank_d = vblank_in;
      tick     = vblank_in & ~vblank_q;
      dx       = '0;
      dy       = '0;
      xpos_d   = xpos_q;
      ypos_d   = ypos_q;
      // Opposing buttons cancel on their axis.
      if (btn_right & ~btn_left)
         dx = 12'(STEP);
      else if (btn_left & ~btn_right)
         dx = 12'(-STEP);
      if (btn_down & ~btn_up)
         dy = 12'(STEP);
      else if (btn_up & ~btn_down)
         dy = 12'(-STEP);
      if (tick) begin
         xpos_d = clamp_pos($signed({1'b0, xpos_q}) + dx, X_MAX);
         ypos_d = clamp_pos($signed({1'b0, ypos_q}) + dy, Y_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vblank_q <= 1'b0;
         xpos_q   <= 11'(INIT_X);
         ypos_q   <= 11'(INIT_Y);
      end else begin
         vblank_q <= vblank_d;
         xpos_q   <= xpos_d;
         ypos_q   <= ypos_d;
      end
   end

   assign xpos = xpos_q;
   assign ypos = ypos_q;

endmodule

// File: rtl/draw_player.sv
// rtl/draw_player.sv - 2-stage sprite overlay on the VGA pixel stream
// PLAYER_BORDER_EN: draw the sprite's outermost row/column in BLACK.
module draw_player
   import vga_pkg::*;
#(
   parameter int          INIT_X       = PLAYER_INIT_X,
   parameter int          INIT_Y       = PLAYER_INIT_Y,
   parameter int          STEP         = PLAYER_STEP,
   parameter logic [11:0] PLAYER_COLOR = YELLOW
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblank_in,
   input  logic        vblank_in,
   input  logic [11:0] rgb_in,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_up,
   input  logic        btn_down,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblank_out,
   output logic        vblank_out,
   output logic [11:0] rgb_out,
   output logic [10:0] xpos,
   output logic [10:0] ypos
);

   vga_timing_t tim1_q, tim1_d, tim2_q, tim2_d;
   logic [11:0] rgb1_q, rgb1_d, rgb2_q, rgb2_d;
   logic        hit1_q, hit1_d;
   logic        edge1_q, edge1_d;
   logic        in_x, in_y;

   player_move_ctl #(
      .INIT_X (INIT_X),
      .INIT_Y (INIT_Y),
      .STEP   (STEP)
   ) u_move (
      .clk       (clk),
      .rst       (rst),
      .vblank_in (vblank_in),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .xpos      (xpos),
      .ypos      (ypos)
   );

   always_comb begin
      tim1_d.hcount = hcount_in;
      tim1_d.vcount = vcount_in;
      tim1_d.hsync  = hsync_in;
      tim1_d.vsync  = vsync_in;
      tim1_d.hblank = hblank_in;
      tim1_d.vblank = vblank_in;
      rgb1_d        = rgb_in;
      // Compare against the registered position so a same-cycle tick moves nothing yet.
      in_x    = ({1'b0, hcount_in} >= {1'b0, xpos}) &&
                ({1'b0, hcount_in} <  ({1'b0, xpos} + 12'(PLAYER_SIZE)));
      in_y    = ({1'b0, vcount_in} >= {1'b0, ypos}) &&
                ({1'b0, vcount_in} <  ({1'b0, ypos} + 12'(PLAYER_SIZE)));
      hit1_d  = ~hblank_in & ~vblank_in & in_x & in_y;
`ifdef PLAYER_BORDER_EN
      edge1_d = (hcount_in == xpos) || (hcount_in == xpos + 11'(PLAYER_SIZE - 1)) ||
                (vcount_in == ypos) || (vcount_in == ypos + 11'(PLAYER_SIZE - 1));
`else
      edge1_d = 1'b0;
`endif
      tim2_d = tim1_q;
      if (tim1_q.hblank | tim1_q.vblank)
         rgb2_d = BLACK;
      else if (hit1_q)
         rgb2_d = edge1_q ? BLACK : PLAYER_COLOR;
      else
         rgb2_d = rgb1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tim1_q  <= '0;
         tim2_q  <= '0;
         rgb1_q  <= '0;
         rgb2_q  <= '0;
         hit1_q  <= 1'b0;
         edge1_q <= 1'b0;
      end else begin
         tim1_q  <= tim1_d;
         tim2_q  <= tim2_d;
         rgb1_q  <= rgb1_d;
         rgb2_q  <= rgb2_d;
         hit1_q  <= hit1_d;
         edge1_q <= edge1_d;
      end
   end

   assign hcount_out = tim2_q.hcount;
   assign vcount_out = tim2_q.vcount;
   assign hsync_out  = tim2_q.hsync;
   assign vsync_out  = tim2_q.vsync;
   assign hblank_out = tim2_q.hblank;
   assign vblank_out = tim2_q.vblank;
   assign rgb_out    = rgb2_q;

endmodule

// File: tb/tb_draw_player.sv
// tb/tb_draw_player.sv - directed self-checking bench for draw_player (honours PLAYER_BORDER_EN)
module tb_draw_player;
   import vga_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst2;
   logic [10:0] hcount_in, vcount_in;
   logic        hsync_in, vsync_in, hblank_in, vblank_in;
   logic [11:0] rgb_in;
   logic        btn_left, btn_right, btn_up, btn_down, btn_left2;
   logic [10:0] hcount_out, vcount_out, xpos, ypos;
   logic        hsync_out, vsync_out, hblank_out, vblank_out;
   logic [11:0] rgb_out;
   logic [10:0] d2_hcount, d2_vcount, d2_xpos, d2_ypos;
   logic        d2_hsync, d2_vsync, d2_hblank, d2_vblank;
   logic [11:0] d2_rgb;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [10:0] h, v;
      logic        hs, vs, hb, vb;
      logic [11:0] rgb;
      bit          chk;
   } exp_t;
   exp_t pipe0, pipe1;

   draw_player dut (
      .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
      .rgb_in(rgb_in), .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
      .btn_down(btn_down), .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .hblank_out(hblank_out),
      .vblank_out(vblank_out), .rgb_out(rgb_out), .xpos(xpos), .ypos(ypos)
   );

   // Second instance starting one pixel from the left edge.
   draw_player #(.INIT_X(1)) dut2 (
      .clk(clk), .rst(rst2), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
      .rgb_in(rgb_in), .btn_left(btn_left2), .btn_right(1'b0), .btn_up(1'b0),
      .btn_down(1'b0), .hcount_out(d2_hcount), .vcount_out(d2_vcount),
      .hsync_out(d2_hsync), .vsync_out(d2_vsync), .hblank_out(d2_hblank),
      .vblank_out(d2_vblank), .rgb_out(d2_rgb), .xpos(d2_xpos), .ypos(d2_ypos)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [11:0] pix(input int h, v, x, y, input logic [11:0] bg,
                                       input logic hb, vb);
      if (hb | vb) return 12'h000;
      if (h >= x && h < x + 15 && v >= y && v < y + 15) begin
`ifdef PLAYER_BORDER_EN
         if (h == x || h == x + 14 || v == y || v == y + 14) return 12'h000;
`endif
         return 12'hff0;
      end
      return bg;
   endfunction

   task automatic step(input int h, v, input logic hb, vb, input logic [11:0] rgb,
                       input logic [11:0] exp_rgb, input bit chk);
      logic hs, vs;
      @(negedge clk);
      if (pipe1.chk) begin
         total++;
         if ({hcount_out, vcount_out, hsync_out, vsync_out, hblank_out, vblank_out, rgb_out} !==
             {pipe1.h, pipe1.v, pipe1.hs, pipe1.vs, pipe1.hb, pipe1.vb, pipe1.rgb}) begin
            bad++;
            $display("FAIL pixel: got h=%0d v=%0d sync=%b%b blank=%b%b rgb=%h want h=%0d v=%0d sync=%b%b blank=%b%b rgb=%h",
                     hcount_out, vcount_out, hsync_out, vsync_out, hblank_out, vblank_out, rgb_out,
                     pipe1.h, pipe1.v, pipe1.hs, pipe1.vs, pipe1.hb, pipe1.vb, pipe1.rgb);
         end
      end
      hs = 1'((h >> 3) & 1);
      vs = 1'((v >> 1) & 1);
      pipe1 = pipe0;
      pipe0 = '{h: 11'(h), v: 11'(v), hs: hs, vs: vs, hb: hb, vb: vb, rgb: exp_rgb, chk: chk};
      hcount_in = 11'(h);
      vcount_in = 11'(v);
      hsync_in  = hs;
      vsync_in  = vs;
      hblank_in = hb;
      vblank_in = vb;
      rgb_in    = rgb;
   endtask

   task automatic clear_pipe();
      pipe0.chk = 1'b0;
      pipe1.chk = 1'b0;
   endtask

   task automatic flush();
      step(1100, 10, 1'b1, 1'b0, BLUE, BLACK, 1'b0);
      step(1101, 10, 1'b1, 1'b0, BLUE, BLACK, 1'b0);
   endtask

   // One frame boundary: checks position just before and just after the vblank rise.
   task automatic frame(input int xb, yb, xa, ya);
      step(520, 390, 1'b0, 1'b0, BLUE, pix(520, 390, xb, yb, BLUE, 1'b0, 1'b0), 1'b1);
      step(100, 770, 1'b1, 1'b1, BLUE, BLACK, 1'b1);
      #1;
      total++;
      if (xpos !== 11'(xb) || ypos !== 11'(yb)) begin
         bad++;
         $display("FAIL pre_tick_pos: got (%0d,%0d) want (%0d,%0d)", xpos, ypos, xb, yb);
      end
      step(101, 770, 1'b1, 1'b1, BLUE, BLACK, 1'b1);
      #1;
      total++;
      if (xpos !== 11'(xa) || ypos !== 11'(ya)) begin
         bad++;
         $display("FAIL post_tick_pos: got (%0d,%0d) want (%0d,%0d)", xpos, ypos, xa, ya);
      end
      step(102, 771, 1'b1, 1'b1, BLUE, BLACK, 1'b1);
      #1;
      total++;
      if (xpos !== 11'(xa) || ypos !== 11'(ya)) begin
         bad++;
         $display("FAIL hold_in_vblank_pos: got (%0d,%0d) want (%0d,%0d)", xpos, ypos, xa, ya);
      end
      flush();
   endtask

   task automatic quick_frame();
      step(10, 10, 1'b0, 1'b0, BLUE, BLUE, 1'b0);
      step(10, 770, 1'b0, 1'b1, BLUE, BLACK, 1'b0);
      step(11, 770, 1'b0, 1'b1, BLUE, BLACK, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1; rst2 = 1'b1;
      btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0; btn_left2 = 0;
      hcount_in = 11'd5; vcount_in = 11'd5; hsync_in = 1; vsync_in = 1;
      hblank_in = 1; vblank_in = 0; rgb_in = 12'hfff;
      clear_pipe();
      repeat (3) @(negedge clk);
      total++;
      if ({hcount_out, vcount_out, hsync_out, vsync_out, hblank_out, vblank_out, rgb_out} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got h=%0d v=%0d rgb=%h want all zero", hcount_out, vcount_out, rgb_out);
      end
      total++;
      if (xpos !== 11'd512) begin bad++; $display("FAIL reset_xpos: got %0d want 512", xpos); end
      total++;
      if (ypos !== 11'd384) begin bad++; $display("FAIL reset_ypos: got %0d want 384", ypos); end
      total++;
      if (d2_xpos !== 11'd1) begin bad++; $display("FAIL reset_dut2_xpos: got %0d want 1", d2_xpos); end
      rst = 1'b0;
   endtask

   task automatic test_overlay();
      logic [11:0] bg;
      for (int v = 380; v <= 400; v++) begin
         bg = (v == 395) ? 12'h5a3 : BLUE;
         for (int h = 506; h <= 532; h++)
            step(h, v, 1'b0, 1'b0, bg, pix(h, v, 512, 384, bg, 1'b0, 1'b0), 1'b1);
      end
      step(515, 390, 1'b1, 1'b0, BLUE, BLACK, 1'b1);
      step(515, 390, 1'b0, 1'b1, BLUE, BLACK, 1'b1);
      step(1100, 390, 1'b1, 1'b0, 12'h0f0, BLACK, 1'b1);
      step(515, 390, 1'b0, 1'b0, BLUE, pix(515, 390, 512, 384, BLUE, 1'b0, 1'b0), 1'b1);
      flush();
   endtask

   task automatic test_move_right();
      btn_right = 1'b1;
      frame(512, 384, 514, 384);
      frame(514, 384, 516, 384);
      frame(516, 384, 518, 384);
      btn_right = 1'b0;
   endtask

   task automatic test_opposing();
      btn_left = 1'b1; btn_right = 1'b1; btn_up = 1'b1;
      frame(518, 384, 518, 382);
      btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0;
   endtask

   task automatic test_clamp();
      rst2 = 1'b0; btn_left2 = 1'b1;
      frame(518, 382, 518, 382);
      total++;
      if (d2_xpos !== 11'd0) begin bad++; $display("FAIL clamp_from_1: got %0d want 0", d2_xpos); end
      quick_frame();
      total++;
      if (d2_xpos !== 11'd0) begin bad++; $display("FAIL clamp_hold_0: got %0d want 0", d2_xpos); end
      btn_left = 1'b1;
      for (int i = 0; i < 300 && xpos != 11'd0; i++) quick_frame();
      total++;
      if (xpos !== 11'd0) begin bad++; $display("FAIL left_reach_0: got %0d want 0", xpos); end
      frame(0, 382, 0, 382);
      btn_left = 1'b0;
      btn_down = 1'b1;
      for (int i = 0; i < 300 && ypos != 11'd753; i++) quick_frame();
      total++;
      if (ypos !== 11'd753) begin bad++; $display("FAIL down_reach_753: got %0d want 753", ypos); end
      frame(0, 753, 0, 753);
      btn_down = 1'b0;
   endtask

   task automatic test_mid_reset();
      for (int h = 590; h <= 599; h++) step(h, 100, 1'b0, 1'b0, BLUE, BLUE, 1'b1);
      @(negedge clk);
      clear_pipe();
      hcount_in = 11'd600; vcount_in = 11'd100; rst = 1'b1;
      @(negedge clk);
      total++;
      if ({hcount_out, vcount_out, hsync_out, vsync_out, hblank_out, vblank_out, rgb_out} !== '0) begin
         bad++;
         $display("FAIL midreset_outputs: got h=%0d v=%0d rgb=%h want all zero", hcount_out, vcount_out, rgb_out);
      end
      total++;
      if (xpos !== 11'd512 || ypos !== 11'd384) begin
         bad++;
         $display("FAIL midreset_pos: got (%0d,%0d) want (512,384)", xpos, ypos);
      end
      rst = 1'b0;
      for (int h = 508; h <= 530; h++)
         step(h, 384, 1'b0, 1'b0, BLUE, pix(h, 384, 512, 384, BLUE, 1'b0, 1'b0), 1'b1);
      flush();
   endtask

   initial begin
      test_reset();
      test_overlay();
      test_move_right();
      test_opposing();
      test_clamp();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
